raycast_pixel_pipe: RTL

- Parametrised, pipelined successor to the combinational colour mapper.
- Produces registered RGB for every screen pixel. Renders a 3D raycast view from a double-buffered per-column wall buffer, plus a configurable minimap overlay with player disc and ray dots.
- Sits between the raycaster (column writer) and the VGA/HDMI encoder (pixel consumer).
- Mode input selects: 3D plus minimap, full-screen map, or 3D only.

---
 rtl/raycast_pixel_pipe.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/raycast_pixel_pipe.sv
// Pixel colour pipeline: double-buffered per-column wall store written by the raycaster,
// read 2 cycles ahead of registered RGB with a 3D view, full map or minimap overlay.
module raycast_pixel_pipe #(
  parameter int NUM_COLS  = 640,
  parameter int HEIGHT_W  = 8,
  parameter int SHADE_W   = 4,
  parameter int Y_CENTER  = 240,
  parameter int MAP_W     = 160,
  parameter int MAP_H     = 120,
  parameter int MAP_SHIFT = 2,
  parameter int DOT_SHIFT = 3,
  parameter int DOT_HW    = 1
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic [1:0]             mode,
  input  logic                   col_valid,
  output logic                   col_ready,
  input  logic [9:0]             col_idx,
  input  logic [HEIGHT_W-1:0]    col_height,
  input  logic [SHADE_W-1:0]     col_shade,
  input  logic                   col_last,
  input  logic                   vsync,
  input  logic                   pix_valid,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [9:0]             X,
  input  logic [9:0]             Y,
  input  logic [9:0]             size,
  input  logic [7:0]             x_vec,
  input  logic [7:0]             y_vec,
  input  logic                   wall_on,
  input  logic [3*SHADE_W-1:0]   wall_color,
  output logic [SHADE_W-1:0]     Red,
  output logic [SHADE_W-1:0]     Green,
  output logic [SHADE_W-1:0]     Blue,
  output logic                   rgb_valid,
  output logic [7:0]             frame_drops,
  output logic                   col_err
);
  localparam int MEM_W = SHADE_W + HEIGHT_W;
  localparam int DOTS  = (1 << DOT_SHIFT) + 1;
  localparam logic [9:0]         NUM_COLS_V = 10'(NUM_COLS);
  localparam logic [9:0]         MAP_W_V    = 10'(MAP_W);
  localparam logic [9:0]         MAP_H_V    = 10'(MAP_H);
  localparam logic [10:0]        Y_CENTER_V = 11'(Y_CENTER);
  localparam logic signed [11:0] DOT_HW_V   = 12'(DOT_HW);
  localparam logic [SHADE_W-1:0] C_0 = '0;
  localparam logic [SHADE_W-1:0] C_3 = SHADE_W'(3);
  localparam logic [SHADE_W-1:0] C_4 = SHADE_W'(4);
  localparam logic [SHADE_W-1:0] C_7 = SHADE_W'(7);
  localparam logic [SHADE_W-1:0] C_F = '1;

  typedef enum logic {FILL = 1'b0, WAIT_SWAP = 1'b1} state_t;

  state_t       state_q, state_d;
  logic         vsync_q, wr_bank_q, wr_bank_d, bank_valid_q, bank_valid_d;
  logic [7:0]   frame_drops_q, frame_drops_d;
  logic         col_err_q, col_err_d;
  logic         col_xfer, col_in_range, vsync_rise;

  assign col_ready    = (state_q == FILL);
  assign col_xfer     = col_valid && col_ready;
  assign col_in_range = (col_idx < NUM_COLS_V);
  assign vsync_rise   = vsync && !vsync_q;
  assign frame_drops  = frame_drops_q;
  assign col_err      = col_err_q;

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    bank_valid_d  = bank_valid_q;
    frame_drops_d = frame_drops_q;
    col_err_d     = col_err_q || (col_xfer && !col_in_range);
    case (state_q)
      FILL: begin
        if (vsync_rise && frame_drops_q != 8'hFF) frame_drops_d = frame_drops_q + 8'd1;
        if (col_xfer && col_last) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vsync_rise) begin
          wr_bank_d    = ~wr_bank_q;
          bank_valid_d = 1'b1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FILL;
      vsync_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      bank_valid_q  <= 1'b0;
      frame_drops_q <= 8'd0;
      col_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync;
      wr_bank_q     <= wr_bank_d;
      bank_valid_q  <= bank_valid_d;
      frame_drops_q <= frame_drops_d;
      col_err_q     <= col_err_d;
    end
  end

  // Column store: the raycaster fills one bank while the pixel side reads the other.
  logic [MEM_W-1:0] bank_mem [2][NUM_COLS];
  logic [MEM_W-1:0] rd_word_q;
  logic [9:0]       rd_addr;

  assign rd_addr = (DrawX < NUM_COLS_V) ? DrawX : 10'd0;

  always_ff @(posedge Clk) begin
    if (col_xfer && col_in_range) bank_mem[wr_bank_q][col_idx] <= {col_shade, col_height};
    rd_word_q <= bank_mem[~wr_bank_q][rd_addr];
  end

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d, s1_wall_on_q, s1_wall_on_d;
  logic                 s1_bank_valid_q, s1_bank_valid_d;
  logic [9:0]           s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [1:0]           s1_mode_q, s1_mode_d;
  logic [3*SHADE_W-1:0] s1_wall_color_q, s1_wall_color_d;

  always_comb begin
    s1_valid_d      = pix_valid;
    s1_x_d          = DrawX;
    s1_y_d          = DrawY;
    s1_mode_d       = mode;
    s1_wall_on_d    = wall_on;
    s1_wall_color_d = wall_color;
    s1_bank_valid_d = bank_valid_q;
  end

  // Stage 2: map coordinates, ray dots, player disc, 3D column
  logic signed [11:0] mx, my, px, py, vx, vy;
  logic               map_px;
  logic [DOTS-1:0]    dot_hit;

  assign px = {2'b00, X};
  assign py = {2'b00, Y};
  assign vx = {{4{x_vec[7]}}, x_vec};
  assign vy = {{4{y_vec[7]}}, y_vec};

  always_comb begin
    mx     = {2'b00, s1_x_q};
    my     = {2'b00, s1_y_q};
    map_px = 1'b0;
    case (s1_mode_q)
      2'd0: begin
        mx     = {2'b00, s1_x_q} << MAP_SHIFT;
        my     = {2'b00, s1_y_q} << MAP_SHIFT;
        map_px = (s1_x_q < MAP_W_V) && (s1_y_q < MAP_H_V);
      end
      2'd1:    map_px = 1'b1;
      default: map_px = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < DOTS; gi++) begin : g_dot
    localparam logic signed [11:0] K = 12'(gi);
    logic signed [11:0] ddx, ddy;
    assign ddx = mx - (px + ((K * vx) >>> DOT_SHIFT));
    assign ddy = my - (py + ((K * vy) >>> DOT_SHIFT));
    assign dot_hit[gi] = (ddx >= -DOT_HW_V) && (ddx <= DOT_HW_V) &&
                         (ddy >= -DOT_HW_V) && (ddy <= DOT_HW_V);
  end

  logic signed [11:0] disc_dx, disc_dy;
  logic signed [23:0] disc_sqx, disc_sqy;
  logic [24:0]        disc_d2;
  logic [19:0]        rad2;
  logic               disc_hit;

  assign disc_dx  = mx - px;
  assign disc_dy  = my - py;
  assign disc_sqx = 24'(disc_dx) * 24'(disc_dx);
  assign disc_sqy = 24'(disc_dy) * 24'(disc_dy);
  assign disc_d2  = {1'b0, disc_sqx} + {1'b0, disc_sqy};
  assign rad2     = {10'd0, size} * {10'd0, size};
  assign disc_hit = (disc_d2 <= {5'd0, rad2});

  // Wall span clamps at row 0 when the half-height exceeds the horizon row.
  logic [10:0]        h11, wall_lo, wall_hi, y11;
  logic [SHADE_W-1:0] s1_shade;

  assign h11      = 11'(rd_word_q[HEIGHT_W-1:0]);
  assign s1_shade = rd_word_q[MEM_W-1:HEIGHT_W];
  assign wall_lo  = (h11 > Y_CENTER_V) ? 11'd0 : Y_CENTER_V - h11;
  assign wall_hi  = Y_CENTER_V + h11;
  assign y11      = {1'b0, s1_y_q};

  logic [SHADE_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               rgb_valid_q, rgb_valid_d;

  always_comb begin
    {red_d, green_d, blue_d} = {C_0, C_0, C_0};
    if (map_px) begin
      if (|dot_hit)          {red_d, green_d, blue_d} = {C_F, C_F, C_F};
      else if (disc_hit)     {red_d, green_d, blue_d} = {C_F, C_7, C_0};
      else if (s1_wall_on_q) {red_d, green_d, blue_d} = s1_wall_color_q;
      else                   {red_d, green_d, blue_d} = {C_0, C_0, C_4};
    end else if (!s1_bank_valid_q) begin
      // No column data yet: split at the horizon so no wall row ever appears.
      if (y11 < Y_CENTER_V) {red_d, green_d, blue_d} = {C_3, C_3, C_7};
      else                  {red_d, green_d, blue_d} = {C_7, C_3, C_3};
    end else if (y11 < wall_lo) begin
      {red_d, green_d, blue_d} = {C_3, C_3, C_7};
    end else if (y11 > wall_hi) begin
      {red_d, green_d, blue_d} = {C_7, C_3, C_3};
    end else begin
      {red_d, green_d, blue_d} = {s1_shade, s1_shade, s1_shade};
    end
    if (!s1_valid_q) {red_d, green_d, blue_d} = {C_0, C_0, C_0};
    rgb_valid_d = s1_valid_q;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q      <= 1'b0;
      s1_x_q          <= 10'd0;
      s1_y_q          <= 10'd0;
      s1_mode_q       <= 2'd0;
      s1_wall_on_q    <= 1'b0;
      s1_wall_color_q <= '0;
      s1_bank_valid_q <= 1'b0;
      red_q           <= '0;
      green_q         <= '0;
      blue_q          <= '0;
      rgb_valid_q     <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_x_q          <= s1_x_d;
      s1_y_q          <= s1_y_d;
      s1_mode_q       <= s1_mode_d;
      s1_wall_on_q    <= s1_wall_on_d;
      s1_wall_color_q <= s1_wall_color_d;
      s1_bank_valid_q <= s1_bank_valid_d;
      red_q           <= red_d;
      green_q         <= green_d;
      blue_q          <= blue_d;
      rgb_valid_q     <= rgb_valid_d;
    end
  end

  assign Red       = red_q;
  assign Green     = green_q;
  assign Blue      = blue_q;
  assign rgb_valid = rgb_valid_q;

endmodule
